// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC owner that fetches micro-instructions and steps DECODE/EXECUTE1/EXECUTE2/FETCH
//  Optional return stack enabled by defining MSEQ_CALL_STACK_EN.
//  Ports:
//   sys_clk, sys_reset         clock, synchronous active-high reset
//   run                        allows new micro-ROM fetches
//   urom_req/urom_addr         micro-ROM request and address (held until urom_ack)
//   urom_ack/urom_data         micro-ROM response pulse and data
//   minst/minst_valid          latched micro-instruction, pulse in DECODE
//   control_state              0=DECODE 1=EXECUTE1 2=EXECUTE2 3=FETCH
//   exec_stall                 holds EXECUTE2
//   is_branch/branch_taken     branch request and condition, sampled on EXECUTE2 exit
//   branch_target              branch/call destination
//   is_call/is_ret             call/return requests (stack build only)
//   upc                        current micro-PC
//   stack_err                  sticky stack over/underflow flag
module micro_sequencer #(
  parameter int BRANCH_ADDR_WIDTH = 10,
  parameter int MINST_WIDTH = 24,
  parameter logic [BRANCH_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_reset,
  input  logic                         run,
  output logic                         urom_req,
  output logic [BRANCH_ADDR_WIDTH-1:0] urom_addr,
  input  logic                         urom_ack,
  input  logic [MINST_WIDTH-1:0]       urom_data,
  output logic [MINST_WIDTH-1:0]       minst,
  output logic                         minst_valid,
  output logic [1:0]                   control_state,
  input  logic                         exec_stall,
  input  logic                         is_branch,
  input  logic                         branch_taken,
  input  logic [BRANCH_ADDR_WIDTH-1:0] branch_target,
  input  logic                         is_call,
  input  logic                         is_ret,
  output logic [BRANCH_ADDR_WIDTH-1:0] upc,
  output logic                         stack_err
);
  typedef enum logic [1:0] {
    S_DECODE = 2'd0,
    S_EXEC1  = 2'd1,
    S_EXEC2  = 2'd2,
    S_FETCH  = 2'd3
  } state_t;
  state_t r_state, w_state_next;
  logic r_req;
  logic [MINST_WIDTH-1:0] r_minst;
  logic [BRANCH_ADDR_WIDTH-1:0] r_upc, w_upc_inc, w_upc_next, w_upc_branch;
  logic w_ack, w_exit;
  // an ack only counts against an outstanding request; strays are dropped
  assign w_ack = r_req & urom_ack;
  assign w_exit = (r_state == S_EXEC2) & ~exec_stall;
  assign w_upc_inc = r_upc + 1'b1;
  assign w_upc_branch = (is_branch & branch_taken) ? branch_target : w_upc_inc;
  always_comb begin
    w_state_next = r_state;
    w_state_next = (r_state == S_FETCH) ? (w_ack ? S_DECODE : S_FETCH) :
                   (r_state == S_DECODE) ? S_EXEC1 :
                   (r_state == S_EXEC1) ? S_EXEC2 :
                   (exec_stall ? S_EXEC2 : S_FETCH);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state <= S_FETCH;
      r_upc   <= RESET_VECTOR;
      r_req   <= 1'b0;
      r_minst <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_exit) r_upc <= w_upc_next;
      // request is raised on EXECUTE2 exit so a 1-cycle ROM gives a 5-cycle op;
      // once raised it is held until acked regardless of run
      r_req <= w_exit ? run :
               (r_state == S_FETCH) ? (r_req ? ~urom_ack : run) : r_req;
      if (w_ack) r_minst <= urom_data;
    end
  end
`ifdef MSEQ_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  logic [SPW-1:0] r_sp;
  logic [BRANCH_ADDR_WIDTH-1:0] r_stack [0:(1<<SPW)-1];
  logic r_stack_err;
  logic w_full, w_empty;
  logic [BRANCH_ADDR_WIDTH-1:0] w_top;
  assign w_full = r_sp == SPW'(STACK_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_top = r_stack[r_sp - 1'b1];
  // return beats call beats branch; a failed push/pop just falls through
  always_comb begin
    w_upc_next = w_upc_branch;
    w_upc_next = is_ret ? (w_empty ? w_upc_inc : w_top) :
                 is_call ? (w_full ? w_upc_inc : branch_target) : w_upc_branch;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else if (w_exit) begin
      if (is_ret) begin
        if (w_empty) r_stack_err <= 1'b1;
        else r_sp <= r_sp - 1'b1;
      end else if (is_call) begin
        if (w_full) r_stack_err <= 1'b1;
        else r_sp <= r_sp + 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_reset && w_exit && !is_ret && is_call && !w_full) r_stack[r_sp] <= w_upc_inc;
  end
  assign stack_err = r_stack_err;
`else
  logic w_unused;
  assign w_unused = ^{is_call, is_ret, STACK_DEPTH[0]};
  always_comb begin
    w_upc_next = w_upc_branch;
  end
  assign stack_err = 1'b0;
`endif
  assign urom_req = r_req;
  assign urom_addr = r_upc;
  assign upc = r_upc;
  assign minst = r_minst;
  assign minst_valid = r_state == S_DECODE;
  assign control_state = r_state;
endmodule
